main: RTL and testbench

MAIN -- requirements
Module: main

---
 rtl/main_if.sv | 15 +
 rtl/main.sv | 46 ++++
 tb/tb_main.sv | 107 ++++++++++
 3 files changed

// File: rtl/main_if.sv
// Shared-address memory port bundle: one write/read request, three registered read views.
interface main_if #(
    parameter int MEM_WIDTH  = 24,
    parameter int ADDR_WIDTH = 8
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [MEM_WIDTH-1:0]  din;
    logic [MEM_WIDTH-1:0]  dout_rf;
    logic [MEM_WIDTH-1:0]  dout_wf;
    logic [MEM_WIDTH-1:0]  dout_nch;

    modport master (output we, addr, din, input dout_rf, dout_wf, dout_nch);
    modport slave  (input we, addr, din, output dout_rf, dout_wf, dout_nch);
endinterface

// File: rtl/main.sv
// Single-port RAM exposing read-first, write-first and no-change registered outputs
// from one storage array; output flops reset asynchronously, the array never resets.
module main #(
    parameter int MEM_WIDTH  = 24,
    parameter int ADDR_WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    main_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [MEM_WIDTH-1:0] mem [DEPTH];
    logic [MEM_WIDTH-1:0] rd_data;
    logic [MEM_WIDTH-1:0] dout_rf_d,  dout_rf_q;
    logic [MEM_WIDTH-1:0] dout_wf_d,  dout_wf_q;
    logic [MEM_WIDTH-1:0] dout_nch_d, dout_nch_q;

    // Array has no reset; writes are gated by rst_n so nothing lands while held in reset.
    always_ff @(posedge clk) begin
        if (rst_n && bus.we) mem[bus.addr] <= bus.din;
    end

    always_comb begin
        rd_data    = mem[bus.addr];
        dout_rf_d  = rd_data;
        dout_wf_d  = bus.we ? bus.din    : rd_data;
        dout_nch_d = bus.we ? dout_nch_q : rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_rf_q  <= '0;
            dout_wf_q  <= '0;
            dout_nch_q <= '0;
        end else begin
            dout_rf_q  <= dout_rf_d;
            dout_wf_q  <= dout_wf_d;
            dout_nch_q <= dout_nch_d;
        end
    end

    assign bus.dout_rf  = dout_rf_q;
    assign bus.dout_wf  = dout_wf_q;
    assign bus.dout_nch = dout_nch_q;
endmodule

// File: tb/tb_main.sv
// Directed vector bench for main: table of hand-computed results plus reset sequences.
module tb_main;
    localparam int MW = 24;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    main_if #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) bus ();
    main #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [MW-1:0] din;
        logic          ck_rf;
        logic [MW-1:0] rf;
        logic [MW-1:0] wf;
        logic [MW-1:0] nch;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %06h expected %06h", name, act, exp);
        end
    endtask

    task automatic step(input logic we, input logic [AW-1:0] a, input logic [MW-1:0] d);
        bus.we = we; bus.addr = a; bus.din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [MW-1:0] exp);
        check({tag, ".rf"},  bus.dout_rf,  exp);
        check({tag, ".wf"},  bus.dout_wf,  exp);
        check({tag, ".nch"}, bus.dout_nch, exp);
    endtask

    initial begin
        //            we   addr   din        ck  rf         wf         nch
        tbl[0]  = '{1'b1, 8'h05, 24'hAAAAAA, 0, 24'h0,      24'hAAAAAA, 24'h000000};
        tbl[1]  = '{1'b0, 8'h05, 24'h000000, 1, 24'hAAAAAA, 24'hAAAAAA, 24'hAAAAAA};
        tbl[2]  = '{1'b0, 8'h05, 24'h000000, 1, 24'hAAAAAA, 24'hAAAAAA, 24'hAAAAAA};
        tbl[3]  = '{1'b1, 8'h05, 24'h111111, 1, 24'hAAAAAA, 24'h111111, 24'hAAAAAA};
        tbl[4]  = '{1'b0, 8'h05, 24'h000000, 1, 24'h111111, 24'h111111, 24'h111111};
        tbl[5]  = '{1'b1, 8'h00, 24'h000001, 0, 24'h0,      24'h000001, 24'h111111};
        tbl[6]  = '{1'b1, 8'hFF, 24'hFFFFFF, 0, 24'h0,      24'hFFFFFF, 24'h111111};
        tbl[7]  = '{1'b0, 8'h00, 24'h000000, 1, 24'h000001, 24'h000001, 24'h000001};
        tbl[8]  = '{1'b0, 8'hFF, 24'h000000, 1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
        tbl[9]  = '{1'b0, 8'h05, 24'h000000, 1, 24'h111111, 24'h111111, 24'h111111};
        tbl[10] = '{1'b1, 8'h10, 24'h123456, 0, 24'h0,      24'h123456, 24'h111111};
        tbl[11] = '{1'b1, 8'h10, 24'h654321, 1, 24'h123456, 24'h654321, 24'h111111};
        tbl[12] = '{1'b0, 8'h10, 24'h000000, 1, 24'h654321, 24'h654321, 24'h654321};

        bus.we = 1'b1; bus.addr = 8'h05; bus.din = 24'h999999;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 24'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].we, tbl[i].addr, tbl[i].din);
            if (tbl[i].ck_rf) check($sformatf("v%0d.rf", i), bus.dout_rf, tbl[i].rf);
            check($sformatf("v%0d.wf", i),  bus.dout_wf,  tbl[i].wf);
            check($sformatf("v%0d.nch", i), bus.dout_nch, tbl[i].nch);
        end

        // Mid-cycle reset with a pending write: outputs clear at once, write is blocked.
        bus.we = 1'b1; bus.addr = 8'h05; bus.din = 24'h222222;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 24'h0);
        @(posedge clk);
        #1;
        check_all("rst_hold", 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h05, 24'h0);
        check_all("mem_kept", 24'h111111);

        // Release directly into a write edge, after re-entering reset.
        rst_n = 1'b0;
        @(negedge clk);
        bus.we = 1'b1; bus.addr = 8'h20; bus.din = 24'hABCDEF;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_wr.wf",  bus.dout_wf,  24'hABCDEF);
        check("rel_wr.nch", bus.dout_nch, 24'h0);
        step(1'b0, 8'h20, 24'h0);
        check_all("rel_rd", 24'hABCDEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
